watermark_fifo: RTL and testbench

//   Parametrised synchronous FIFO, the next-generation UART TX/RX buffer.
//   - Full occupancy count, so all DEPTH entries are usable.
//   - Programmable watermark flag with TX/RX polarity, for interrupt generation.
//   - Synchronous flush, first-word-fall-through read and simultaneous read/write when full.
//   - Sits between the UART register bank (CPU side) and the UART shift engine.

---
 rtl/watermark_fifo_pkg.sv | 12 +
 rtl/watermark_fifo_counter.sv | 38 +++
 rtl/watermark_fifo.sv | 141 ++++++++++++++
 tb/tb_watermark_fifo.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/watermark_fifo_pkg.sv
// Shared constants and helpers for the watermark FIFO (UART TX/RX buffer).
package watermark_fifo_pkg;

    localparam int WM_MODE_RX = 0;
    localparam int WM_MODE_TX = 1;

    // Pointer width for a power-of-two depth; pointers wrap naturally at this width.
    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/watermark_fifo_counter.sv
// Synchronous up/down counter with parallel load, used for FIFO pointers and occupancy.
module watermark_fifo_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_value;
        end else if (inc && !dec) begin
            value_d = value_q + W'(1);
        end else if (dec && !inc) begin
            value_d = value_q - W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/watermark_fifo.sv
// Synchronous FWFT FIFO with full occupancy count and programmable watermark flag.
// Optional sticky overflow/underflow flags are enabled by defining WATERMARK_FIFO_ERR_EN.
module watermark_fifo
    import watermark_fifo_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 8,
    parameter int WM_MODE   = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_SIZE-1:0]     wr_data,
    input  logic                     rd_en,
    output logic [DATA_SIZE-1:0]     rd_data,
    input  logic [$clog2(DEPTH):0]   watermark_level,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     watermark
`ifdef WATERMARK_FIFO_ERR_EN
    ,
    input  logic                     err_clear,
    output logic                     overflow,
    output logic                     underflow
`endif
);

    localparam int PTR_W = fifo_ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count_q;
    logic                 rd_acc;
    logic                 wr_acc;
    logic                 rd_step;
    logic                 wr_step;
    logic [DATA_SIZE-1:0] mem [DEPTH];

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // A push while full is only taken when a pop frees the head slot in the same cycle.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    // Flush overrides any access, so nothing advances or is written on a flush cycle.
    assign rd_step = rd_acc & ~flush;
    assign wr_step = wr_acc & ~flush;

    watermark_fifo_counter #(.W(PTR_W)) u_rd_ptr (
        .clock      (clock),
        .reset      (reset),
        .load       (flush),
        .load_value ('0),
        .inc        (rd_step),
        .dec        (1'b0),
        .value      (rd_ptr)
    );

    watermark_fifo_counter #(.W(PTR_W)) u_wr_ptr (
        .clock      (clock),
        .reset      (reset),
        .load       (flush),
        .load_value ('0),
        .inc        (wr_step),
        .dec        (1'b0),
        .value      (wr_ptr)
    );

    watermark_fifo_counter #(.W(CNT_W)) u_count (
        .clock      (clock),
        .reset      (reset),
        .load       (flush),
        .load_value ('0),
        .inc        (wr_step),
        .dec        (rd_step),
        .value      (count_q)
    );

    always_ff @(posedge clock) begin
        if (wr_step) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign count   = count_q;

    generate
        if (WM_MODE == WM_MODE_TX) begin : g_wm_tx
            assign watermark = (count_q < watermark_level);
        end else begin : g_wm_rx
            assign watermark = (count_q > watermark_level);
        end
    endgenerate

`ifdef WATERMARK_FIFO_ERR_EN
    logic overflow_q;
    logic overflow_d;
    logic underflow_q;
    logic underflow_d;

    // A new error in the same cycle as err_clear wins; flush clears unconditionally.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (err_clear) begin
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
            if (wr_en && !wr_acc) begin
                overflow_d = 1'b1;
            end
            if (rd_en && !rd_acc) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_watermark_fifo.sv
// Directed bench for watermark_fifo: one RX-mode and one TX-mode instance share stimulus.
module tb_watermark_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [CW-1:0] level_rx;
    logic [CW-1:0] level_tx;

    logic [DW-1:0] rd_data_rx, rd_data_tx;
    logic [CW-1:0] count_rx, count_tx;
    logic          empty_rx, empty_tx;
    logic          full_rx, full_tx;
    logic          wm_rx, wm_tx;

    int checks = 0;
    int errors = 0;

`ifdef WATERMARK_FIFO_ERR_EN
    logic err_clear;
    logic ovf_rx, unf_rx, ovf_tx, unf_tx;
`endif

    always #5 clk = ~clk;

    watermark_fifo #(.DATA_SIZE(DW), .DEPTH(DEPTH), .WM_MODE(0)) dut_rx (
        .clock           (clk),
        .reset           (reset),
        .flush           (flush),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .rd_en           (rd_en),
        .rd_data         (rd_data_rx),
        .watermark_level (level_rx),
        .count           (count_rx),
        .empty           (empty_rx),
        .full            (full_rx),
        .watermark       (wm_rx)
`ifdef WATERMARK_FIFO_ERR_EN
        ,
        .err_clear       (err_clear),
        .overflow        (ovf_rx),
        .underflow       (unf_rx)
`endif
    );

    watermark_fifo #(.DATA_SIZE(DW), .DEPTH(DEPTH), .WM_MODE(1)) dut_tx (
        .clock           (clk),
        .reset           (reset),
        .flush           (flush),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .rd_en           (rd_en),
        .rd_data         (rd_data_tx),
        .watermark_level (level_tx),
        .count           (count_tx),
        .empty           (empty_tx),
        .full            (full_tx),
        .watermark       (wm_tx)
`ifdef WATERMARK_FIFO_ERR_EN
        ,
        .err_clear       (err_clear),
        .overflow        (ovf_tx),
        .underflow       (unf_tx)
`endif
    );

    // Apply one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic cycle(input logic w, input logic [DW-1:0] wd, input logic r, input logic f);
        wr_en   = w;
        wr_data = wd;
        rd_en   = r;
        flush   = f;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
        $display("txn wr=%0b wd=%02h rd=%0b fl=%0b -> count=%0d rd_data=%02h empty=%0b full=%0b wm_rx=%0b wm_tx=%0b",
                 w, wd, r, f, count_rx, rd_data_rx, empty_rx, full_rx, wm_rx, wm_tx);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        flush    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wr_data  = '0;
        level_rx = CW'(3);
        level_tx = CW'(2);
`ifdef WATERMARK_FIFO_ERR_EN
        err_clear = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (count_rx !== CW'(0) || empty_rx !== 1'b1 || full_rx !== 1'b0) begin
            errors++;
            $display("FAIL reset_state count=%0d empty=%0b full=%0b expected 0/1/0", count_rx, empty_rx, full_rx);
        end
        checks++;
        if (wm_rx !== 1'b0 || wm_tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_watermark rx=%0b tx=%0b expected rx=0 tx=1", wm_rx, wm_tx);
        end
    endtask

    // Fill 1..8 checking both watermark polarities on the way, then overfill and drain.
    task automatic test_fill_drain_watermark();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, DW'(i), 1'b0, 1'b0);
            if (i == 1) begin
                checks++;
                if (wm_tx !== 1'b1) begin errors++; $display("FAIL tx_wm_count1 got %0b expected 1", wm_tx); end
            end
            if (i == 2) begin
                checks++;
                if (wm_tx !== 1'b0) begin errors++; $display("FAIL tx_wm_count2 got %0b expected 0", wm_tx); end
            end
            if (i == 3) begin
                checks++;
                if (wm_rx !== 1'b0) begin errors++; $display("FAIL rx_wm_count3 got %0b expected 0", wm_rx); end
            end
            if (i == 4) begin
                checks++;
                if (wm_rx !== 1'b1) begin errors++; $display("FAIL rx_wm_count4 got %0b expected 1", wm_rx); end
                level_rx = CW'(4);
                #1;
                checks++;
                if (wm_rx !== 1'b0) begin errors++; $display("FAIL rx_wm_level_change got %0b expected 0", wm_rx); end
                level_rx = CW'(3);
            end
        end
        checks++;
        if (full_rx !== 1'b1 || count_rx !== CW'(8) || rd_data_rx !== 8'h01) begin
            errors++;
            $display("FAIL fill full=%0b count=%0d head=%02h expected 1/8/01", full_rx, count_rx, rd_data_rx);
        end
        cycle(1'b1, 8'h99, 1'b0, 1'b0);
        checks++;
        if (count_rx !== CW'(8) || rd_data_rx !== 8'h01) begin
            errors++;
            $display("FAIL overfill count=%0d head=%02h expected 8/01", count_rx, rd_data_rx);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            checks++;
            if (rd_data_rx !== DW'(i)) begin
                errors++;
                $display("FAIL drain_%0d got %02h expected %02h", i, rd_data_rx, DW'(i));
            end
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (empty_rx !== 1'b1 || count_rx !== CW'(0)) begin
            errors++;
            $display("FAIL drained empty=%0b count=%0d expected 1/0", empty_rx, count_rx);
        end
    endtask

    task automatic test_full_rw();
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
        checks++;
        if (rd_data_rx !== 8'h01) begin errors++; $display("FAIL full_rw_head got %02h expected 01", rd_data_rx); end
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        checks++;
        if (count_rx !== CW'(8) || full_rx !== 1'b1 || rd_data_rx !== 8'h02) begin
            errors++;
            $display("FAIL full_rw count=%0d full=%0b head=%02h expected 8/1/02", count_rx, full_rx, rd_data_rx);
        end
        for (int i = 2; i <= DEPTH + 1; i++) begin
            logic [DW-1:0] exp_v;
            exp_v = (i <= DEPTH) ? DW'(i) : 8'hAA;
            checks++;
            if (rd_data_rx !== exp_v) begin
                errors++;
                $display("FAIL full_rw_pop_%0d got %02h expected %02h", i, rd_data_rx, exp_v);
            end
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (empty_rx !== 1'b1) begin errors++; $display("FAIL full_rw_empty got %0b expected 1", empty_rx); end
    endtask

    task automatic test_empty_rw();
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        checks++;
        if (count_rx !== CW'(1) || empty_rx !== 1'b0 || rd_data_rx !== 8'h55) begin
            errors++;
            $display("FAIL empty_rw count=%0d empty=%0b data=%02h expected 1/0/55", count_rx, empty_rx, rd_data_rx);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (empty_rx !== 1'b1) begin errors++; $display("FAIL empty_rw_pop empty=%0b expected 1", empty_rx); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
        checks++;
        if (count_rx !== CW'(5)) begin errors++; $display("FAIL flush_pre count=%0d expected 5", count_rx); end
        cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        checks++;
        if (count_rx !== CW'(0) || empty_rx !== 1'b1 || count_tx !== CW'(0)) begin
            errors++;
            $display("FAIL flush count=%0d empty=%0b expected 0/1", count_rx, empty_rx);
        end
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        checks++;
        if (count_rx !== CW'(1) || rd_data_rx !== 8'h77) begin
            errors++;
            $display("FAIL flush_after count=%0d head=%02h expected 1/77", count_rx, rd_data_rx);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

`ifdef WATERMARK_FIFO_ERR_EN
    task automatic test_errors();
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (unf_rx !== 1'b1 || ovf_rx !== 1'b0) begin
            errors++;
            $display("FAIL underflow unf=%0b ovf=%0b expected 1/0", unf_rx, ovf_rx);
        end
        err_clear = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b0);
        err_clear = 1'b0;
        checks++;
        if (unf_rx !== 1'b0) begin errors++; $display("FAIL err_clear unf=%0b expected 0", unf_rx); end
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++;
        if (ovf_rx !== 1'b1 || ovf_tx !== 1'b1) begin
            errors++;
            $display("FAIL overflow rx=%0b tx=%0b expected 1/1", ovf_rx, ovf_tx);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (ovf_rx !== 1'b0 || empty_rx !== 1'b1) begin
            errors++;
            $display("FAIL flush_err ovf=%0b empty=%0b expected 0/1", ovf_rx, empty_rx);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain_watermark();
        test_full_rw();
        test_empty_rw();
        test_flush();
`ifdef WATERMARK_FIFO_ERR_EN
        test_errors();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
